data_mem_arbiter: RTL and testbench

- Shares the single data-memory port (req/gnt/rvalid handshake) between two requesters.
  - Port 0: the LSU.
  - Port 1: a secondary master (debug/DMA loader).
- Sequences each access through grant and response phases.
- Keeps one transaction outstanding at a time and uses round-robin priority.
- Rejects misaligned word accesses, and times out if no response arrives.

---
 rtl/data_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single data-memory port: round-robin winner,
// one outstanding access, misalignment rejection and a response timeout.
module data_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       rq_req_i,
    input  logic [1:0][31:0] rq_addr_i,
    input  logic [1:0]       rq_we_i,
    input  logic [1:0][3:0]  rq_be_i,
    input  logic [1:0][31:0] rq_wdata_i,
    output logic [1:0]       rq_gnt_o,
    output logic [1:0]       rq_rvalid_o,
    output logic [31:0]      rq_rdata_o,
    output logic [1:0]       rq_err_o,
    output logic             data_req_o,
    output logic [31:0]      data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a requester holds rq_req_i until its one-cycle rq_gnt_o pulse;
    // memory side holds data_req_o/data_* stable until data_gnt_i, then one
    // data_rvalid_i pulse closes the access.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any_req;
    logic             w_winner;
    logic             w_illegal;
    logic             w_timeout;

    function automatic logic is_illegal(input logic [31:0] addr, input logic [3:0] be);
        logic bad;
        bad = 1'b0;
        if (be == 4'h0)
            bad = 1'b1;
        else if (be == 4'hF)
            bad = (addr[1:0] != 2'b00);
        else if (be == 4'h3 || be == 4'hC)
            bad = addr[0];
        return bad;
    endfunction

    assign w_any_req = |rq_req_i;
    assign w_winner  = (rq_req_i == 2'b11) ? r_ptr : rq_req_i[1];
    assign w_illegal = is_illegal(rq_addr_i[w_winner], rq_be_i[w_winner]);
    // The counter holds cycles already spent waiting, so the current cycle is the last one.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign dbg_state_o = r_state;

    always_comb begin
        rq_gnt_o     = 2'b00;
        rq_rvalid_o  = 2'b00;
        rq_rdata_o   = 32'h0;
        rq_err_o     = 2'b00;
        data_req_o   = 1'b0;
        data_addr_o  = 32'h0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (w_any_req && w_illegal) begin
                        rq_gnt_o[w_winner] = 1'b1;
                        rq_err_o[w_winner] = 1'b1;
                    end
                end
                WAIT_GNT: begin
                    data_req_o   = 1'b1;
                    data_addr_o  = r_addr;
                    data_we_o    = r_we;
                    data_be_o    = r_be;
                    data_wdata_o = r_wdata;
                    if (data_gnt_i) begin
                        rq_gnt_o[r_owner] = 1'b1;
                        if (data_rvalid_i) begin
                            rq_rvalid_o[r_owner] = 1'b1;
                            rq_rdata_o           = r_we ? 32'h0 : data_rdata_i;
                        end
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        rq_rvalid_o[r_owner] = 1'b1;
                        rq_rdata_o           = r_we ? 32'h0 : data_rdata_i;
                    end else if (w_timeout) begin
                        rq_rvalid_o[r_owner] = 1'b1;
                        rq_err_o[r_owner]    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= 32'h0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        if (w_illegal) begin
                            r_ptr <= ~w_winner;
                        end else begin
                            r_owner <= w_winner;
                            r_addr  <= rq_addr_i[w_winner];
                            r_we    <= rq_we_i[w_winner];
                            r_be    <= rq_be_i[w_winner];
                            r_wdata <= rq_wdata_i[w_winner];
                            r_state <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) begin
                        r_cnt <= '0;
                        if (data_rvalid_i) begin
                            r_ptr   <= ~r_owner;
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT_RVALID;
                        end
                    end
                end
                WAIT_RVALID: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (data_rvalid_i || w_timeout) begin
                        r_cnt   <= '0;
                        r_ptr   <= ~r_owner;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: hand-computed expectations checked with
// immediate assertions, one linear sequence of steps.
module tb_data_mem_arbiter;

    logic             clock;
    logic             reset;
    logic [1:0]       rq_req_i;
    logic [1:0][31:0] rq_addr_i;
    logic [1:0]       rq_we_i;
    logic [1:0][3:0]  rq_be_i;
    logic [1:0][31:0] rq_wdata_i;
    logic [1:0]       rq_gnt_o;
    logic [1:0]       rq_rvalid_o;
    logic [31:0]      rq_rdata_o;
    logic [1:0]       rq_err_o;
    logic             data_req_o;
    logic [31:0]      data_addr_o;
    logic             data_we_o;
    logic [3:0]       data_be_o;
    logic [31:0]      data_wdata_o;
    logic             data_gnt_i;
    logic             data_rvalid_i;
    logic [31:0]      data_rdata_i;
    logic [1:0]       dbg_state_o;

    int n_vec  = 0;
    int n_miss = 0;
    int req_cycles = 0;
    int gnt0_pulses = 0;

    data_mem_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .rq_req_i     (rq_req_i),
        .rq_addr_i    (rq_addr_i),
        .rq_we_i      (rq_we_i),
        .rq_be_i      (rq_be_i),
        .rq_wdata_i   (rq_wdata_i),
        .rq_gnt_o     (rq_gnt_o),
        .rq_rvalid_o  (rq_rvalid_o),
        .rq_rdata_o   (rq_rdata_o),
        .rq_err_o     (rq_err_o),
        .data_req_o   (data_req_o),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (data_req_o) req_cycles++;
        if (rq_gnt_o[0]) gnt0_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata);
        rq_req_i[p]   = 1'b1;
        rq_addr_i[p]  = addr;
        rq_we_i[p]    = we;
        rq_be_i[p]    = be;
        rq_wdata_i[p] = wdata;
    endtask

    task automatic clr_req(input int p);
        rq_req_i[p]   = 1'b0;
        rq_addr_i[p]  = 32'h0;
        rq_we_i[p]    = 1'b0;
        rq_be_i[p]    = 4'h0;
        rq_wdata_i[p] = 32'h0;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_rv;
        int         exp_owner;

        reset = 1'b0;
        rq_req_i = 2'b00;
        rq_addr_i = '0;
        rq_we_i = 2'b00;
        rq_be_i = '0;
        rq_wdata_i = '0;
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'hCAFE_F00D;
        set_req(1, 32'h0, 1'b0, 4'h0, 32'h0);

        // Reset: outputs stay 0 even with an illegal request and a stray rvalid.
        next_cycle();
        next_cycle();
        #1;
        chk("rst_gnt", 32'(rq_gnt_o), 32'h0);
        chk("rst_err", 32'(rq_err_o), 32'h0);
        chk("rst_rvalid", 32'(rq_rvalid_o), 32'h0);
        chk("rst_data_req", 32'(data_req_o), 32'h0);
        chk("rst_state", 32'(dbg_state_o), 32'h0);
        clr_req(1);
        data_rvalid_i = 1'b0;
        reset = 1'b1;
        next_cycle();

        // Single LSU load, memory gnt on the third WAIT_GNT cycle.
        set_req(0, 32'h100, 1'b0, 4'hF, 32'h0);
        req_cycles = 0;
        gnt0_pulses = 0;
        #1;
        chk("ld_idle_gnt", 32'(rq_gnt_o), 32'h0);
        next_cycle();
        #1;
        chk("ld_wg1_req", 32'(data_req_o), 32'h1);
        chk("ld_wg1_addr", data_addr_o, 32'h100);
        chk("ld_wg1_be", 32'(data_be_o), 32'hF);
        chk("ld_wg1_gnt", 32'(rq_gnt_o), 32'h0);
        next_cycle();
        #1;
        chk("ld_wg2_req", 32'(data_req_o), 32'h1);
        next_cycle();
        data_gnt_i = 1'b1;
        #1;
        chk("ld_gnt", 32'(rq_gnt_o), 32'h1);
        next_cycle();
        clr_req(0);
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("ld_rvalid", 32'(rq_rvalid_o), 32'h1);
        chk("ld_rdata", rq_rdata_o, 32'hDEAD_BEEF);
        chk("ld_wr_req", 32'(data_req_o), 32'h0);
        next_cycle();
        data_rvalid_i = 1'b0;
        #1;
        chk("ld_back_idle", 32'(dbg_state_o), 32'h0);
        chk("ld_rdata_zero", rq_rdata_o, 32'h0);
        chk("ld_req_cycles", 32'(req_cycles), 32'd3);
        chk("ld_gnt_pulses", 32'(gnt0_pulses), 32'd1);

        // Contention from reset: grants alternate 0,1,0,1.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        set_req(0, 32'h200, 1'b0, 4'hF, 32'h0);
        set_req(1, 32'h300, 1'b0, 4'hF, 32'h0);
        data_gnt_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            data_rvalid_i = (k % 3 == 2);
            data_rdata_i = 32'hA000_0000 + 32'(k);
            #1;
            exp_owner = (k / 3) % 2;
            exp_g = (k % 3 == 1) ? ((exp_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rv = (k % 3 == 2) ? ((exp_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("rr_gnt_%0d", k), 32'(rq_gnt_o), 32'(exp_g));
            chk($sformatf("rr_rvalid_%0d", k), 32'(rq_rvalid_o), 32'(exp_rv));
            chk($sformatf("rr_rdata_%0d", k), rq_rdata_o,
                (k % 3 == 2) ? 32'hA000_0000 + 32'(k) : 32'h0);
            next_cycle();
        end
        clr_req(0);
        clr_req(1);
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;

        // Misaligned port-1 store: immediate gnt+err, no memory request.
        req_cycles = 0;
        set_req(1, 32'h102, 1'b1, 4'hF, 32'h1111_1111);
        #1;
        chk("mis_gnt", 32'(rq_gnt_o), 32'h2);
        chk("mis_err", 32'(rq_err_o), 32'h2);
        chk("mis_data_req", 32'(data_req_o), 32'h0);
        next_cycle();
        clr_req(1);
        set_req(0, 32'h8, 1'b1, 4'h3, 32'h1234_5678);
        #1;
        chk("mis_no_req", 32'(req_cycles), 32'd0);
        chk("mis_state", 32'(dbg_state_o), 32'h0);
        chk("st_idle_gnt", 32'(rq_gnt_o), 32'h0);

        // Store with gnt and rvalid in the same cycle.
        next_cycle();
        data_gnt_i = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("st_gnt", 32'(rq_gnt_o), 32'h1);
        chk("st_rvalid", 32'(rq_rvalid_o), 32'h1);
        chk("st_rdata", rq_rdata_o, 32'h0);
        chk("st_addr", data_addr_o, 32'h8);
        chk("st_we", 32'(data_we_o), 32'h1);
        chk("st_be", 32'(data_be_o), 32'h3);
        chk("st_wdata", data_wdata_o, 32'h1234_5678);
        next_cycle();
        clr_req(0);
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        #1;
        chk("st_idle", 32'(dbg_state_o), 32'h0);
        chk("st_no_rvalid", 32'(rq_rvalid_o), 32'h0);

        // Both request, pointer at port 1 whose be=0 is illegal.
        set_req(0, 32'h40, 1'b0, 4'hF, 32'h0);
        set_req(1, 32'h0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("be0_gnt", 32'(rq_gnt_o), 32'h2);
        chk("be0_err", 32'(rq_err_o), 32'h2);
        next_cycle();
        clr_req(1);
        #1;
        chk("to_idle_gnt", 32'(rq_gnt_o), 32'h0);
        chk("to_idle_err", 32'(rq_err_o), 32'h0);

        // Timeout: rvalid never arrives, abort on the 16th cycle after gnt.
        next_cycle();
        data_gnt_i = 1'b1;
        #1;
        chk("to_gnt", 32'(rq_gnt_o), 32'h1);
        chk("to_addr", data_addr_o, 32'h40);
        next_cycle();
        clr_req(0);
        data_gnt_i = 1'b0;
        data_rdata_i = 32'h5555_5555;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk($sformatf("to_rvalid_%0d", i), 32'(rq_rvalid_o), (i == 16) ? 32'h1 : 32'h0);
            chk($sformatf("to_err_%0d", i), 32'(rq_err_o), (i == 16) ? 32'h1 : 32'h0);
            chk($sformatf("to_state_%0d", i), 32'(dbg_state_o), 32'h2);
            if (i == 16) chk("to_rdata", rq_rdata_o, 32'h0);
            next_cycle();
        end
        #1;
        chk("to_back_idle", 32'(dbg_state_o), 32'h0);
        chk("to_req_low", 32'(data_req_o), 32'h0);

        // Reset during WAIT_RVALID; late rvalid ignored, pointer back to port 0.
        set_req(0, 32'h80, 1'b0, 4'hF, 32'h0);
        next_cycle();
        data_gnt_i = 1'b1;
        #1;
        chk("mr_gnt", 32'(rq_gnt_o), 32'h1);
        next_cycle();
        clr_req(0);
        data_gnt_i = 1'b0;
        #1;
        chk("mr_wait", 32'(dbg_state_o), 32'h2);
        next_cycle();
        reset = 1'b0;
        set_req(1, 32'h0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("mr_rst_gnt", 32'(rq_gnt_o), 32'h0);
        chk("mr_rst_err", 32'(rq_err_o), 32'h0);
        chk("mr_rst_req", 32'(data_req_o), 32'h0);
        next_cycle();
        reset = 1'b1;
        clr_req(1);
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'h0000_0077;
        #1;
        chk("mr_rvalid_ignored", 32'(rq_rvalid_o), 32'h0);
        chk("mr_rdata", rq_rdata_o, 32'h0);
        chk("mr_state", 32'(dbg_state_o), 32'h0);
        next_cycle();
        data_rvalid_i = 1'b0;
        set_req(0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_req(1, 32'h0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("mr_ptr_gnt", 32'(rq_gnt_o), 32'h1);
        chk("mr_ptr_err", 32'(rq_err_o), 32'h1);
        next_cycle();
        clr_req(0);
        clr_req(1);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
